// File: rtl/qam_pkg.sv
// Shared 16-QAM definitions: controller state encoding, Gray level constants
// and the bit-pair to level mapping used by the transmit mapper.
package qam_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    FULL = 2'b10,
    SEND = 2'b11
  } state_e;

  localparam logic signed [2:0] LVL_M3 = 3'sb101;
  localparam logic signed [2:0] LVL_M1 = 3'sb111;
  localparam logic signed [2:0] LVL_P1 = 3'sb001;
  localparam logic signed [2:0] LVL_P3 = 3'sb011;

  // Gray order along one axis: 00, 01, 11, 10 -> -3, -1, +1, +3
  function automatic logic signed [2:0] gray2level(input logic [1:0] pair);
    logic signed [2:0] lvl;
    case (pair)
      2'b00:   lvl = LVL_M3;
      2'b01:   lvl = LVL_M1;
      2'b11:   lvl = LVL_P1;
      2'b10:   lvl = LVL_P3;
      default: lvl = LVL_M3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam_tx_fifo.sv
// Show-ahead synchronous FIFO of 4-bit QAM words with wrap-bit pointers,
// occupancy count and a synchronous flush.
module qam_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [3:0]        din,
  output logic [3:0]        dout,
  output logic [ADDR_W:0]   count,
  output logic              wfull,
  output logic              rdempty
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [3:0]      mem_q [DEPTH];
  logic [ADDR_W:0] wr_ptr_q;
  logic [ADDR_W:0] rd_ptr_q;
  logic            push_ok_s;
  logic            pop_ok_s;

  assign push_ok_s = push && !wfull && !flush;
  assign pop_ok_s  = pop && !rdempty && !flush;

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= din;
    end
  end

  // Read/write pointers, cleared by reset or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  assign dout    = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdempty = (wr_ptr_q == rd_ptr_q);
  assign wfull   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

endmodule

// File: rtl/qam_mapper_controller.sv
// 16-QAM transmit controller: host loads words into a FIFO, start drains it
// as one Gray-mapped I/Q symbol every SYM_PERIOD cycles.
module qam_mapper_controller
  import qam_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int SYM_PERIOD = 4
) (
  input  logic              dclk,
  input  logic              reset,
  input  logic              enable,
  input  logic              write,
  input  logic [3:0]        wdata,
  input  logic              start,
  output logic signed [2:0] sym_i,
  output logic signed [2:0] sym_q,
  output logic              sym_valid,
  output logic              space,
  output logic              complete,
  output logic              overflow,
  output logic              wfull,
  output logic              rdempty,
  output logic [1:0]        state
);

  localparam int              TW         = $clog2(SYM_PERIOD);
  localparam logic [TW-1:0]   TIMER_LOAD = TW'(SYM_PERIOD - 1);
  localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
  localparam logic [ADDR_W:0] LAST_SLOT  = (ADDR_W + 1)'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q;
  logic signed [2:0] sym_i_q, sym_q_q;
  logic              sym_valid_q, complete_q, overflow_q;
  logic              push_s, pop_s, flush_s;
  logic [3:0]        fifo_dout_s;
  logic [ADDR_W:0]   fifo_count_s;
  logic              wfull_s, rdempty_s;

  qam_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk     (dclk),
    .rst_n   (reset),
    .flush   (flush_s),
    .push    (push_s),
    .pop     (pop_s),
    .din     (wdata),
    .dout    (fifo_dout_s),
    .count   (fifo_count_s),
    .wfull   (wfull_s),
    .rdempty (rdempty_s)
  );

  // FIFO strobes and next controller state
  always_comb begin
    flush_s = !enable;
    push_s  = enable && (state_q == LOAD) && write && !wfull_s;
    pop_s   = enable && (state_q == SEND) && (timer_q == '0) && !rdempty_s;
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          // start wins over the fill-up transition when both happen together
          if (start && (!rdempty_s || push_s))             state_d = SEND;
          else if (push_s && (fifo_count_s == LAST_SLOT))   state_d = FULL;
          else                                              state_d = LOAD;
        end
        FULL: begin
          if (start) state_d = SEND;
          else       state_d = FULL;
        end
        SEND: begin
          if ((timer_q == '0) && rdempty_s) state_d = LOAD;
          else                              state_d = SEND;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Controller state, symbol timer and registered outputs
  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      sym_i_q     <= 3'sb000;
      sym_q_q     <= 3'sb000;
      sym_valid_q <= 1'b0;
      complete_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!enable) begin
        timer_q     <= '0;
        sym_valid_q <= 1'b0;
        complete_q  <= 1'b0;
        overflow_q  <= 1'b0;
      end else begin
        sym_valid_q <= pop_s;
        complete_q  <= (state_q == SEND) && (state_d == LOAD);
        if (write && !push_s && (state_q != IDLE)) begin
          overflow_q <= 1'b1;
        end
        if (pop_s) begin
          sym_i_q <= gray2level(fifo_dout_s[3:2]);
          sym_q_q <= gray2level(fifo_dout_s[1:0]);
          timer_q <= TIMER_LOAD;
        end else if ((state_q == SEND) && (timer_q != '0)) begin
          timer_q <= timer_q - TIMER_ONE;
        end else begin
          timer_q <= '0;
        end
      end
    end
  end

  assign sym_i     = sym_i_q;
  assign sym_q     = sym_q_q;
  assign sym_valid = sym_valid_q;
  assign complete  = complete_q;
  assign overflow  = overflow_q;
  assign wfull     = wfull_s;
  assign rdempty   = rdempty_s;
  assign space     = (state_q == LOAD) && !wfull_s;
  assign state     = state_q;

endmodule
